spi_fault_injector: RTL
=======================

Name: spi_fault_injector

Overview:
- Parametrised successor to the fixed-function SD-over-SPI injector.
- Watches decoded command and byte-boundary events from the SPI sniffer and arms on a programmable set of command indices.
- Waits a programmable number of byte boundaries, then overrides or XORs a programmable bit pattern onto MOSI or MISO.
- Sits inline on the MOSI/MISO wires between host and card. It is the generic injection engine for error-path testing.

Parameters:
- NUM_TRIG, 2, number of command-match trigger slots
- PAT_W, 8, injected pattern length in bits (>=1), sent MSB first
- SKIP_W, 8, width of the byte-delay counter

Ports:
- CLK  in  1  SPI clock; all state updates on falling edge
- async_reset_n  in  1  asynchronous active-low reset
- MOSI_IN  in  1  MOSI from host
- MOSI_OUT  out  1  MOSI to card
- MISO_IN  in  1  MISO from card
- MISO_OUT  out  1  MISO to host
- io_MOSIReadSuccess  in  1  level; rising edge means a command frame was decoded; falling edge means the transaction ended
- io_MOSICommand  in  6  decoded command index, valid when io_MOSIReadSuccess is high
- io_BufferChanged  in  1  rising edge means a byte boundary
- cfg_enable  in  1  global enable
- cfg_trig_valid  in  NUM_TRIG  per-slot valid
- cfg_trig_cmd  in  NUM_TRIG*6  per-slot command index; slot i is bits [6i+5:6i]
- cfg_skip  in  SKIP_W  byte boundaries to wait after trigger
- cfg_pattern  in  PAT_W  bits to inject
- cfg_mode  in  2  00 replace MOSI, 01 XOR MOSI, 10 replace MISO, 11 XOR MISO
- cfg_repeat  in  1  1 re-arms after each injection; 0 is one-shot
- io_InjectCount  out  8  completed injections, saturating
- io_Injecting  out  1  high while an override is active
- io___dbg_state  out  8  {5'b0, state}

Behaviour:
- Edge detect: hist registers for io_MOSIReadSuccess and io_BufferChanged, updated every falling edge. An edge means hist is 0 and the input is 1, or the reverse for a falling edge.
- Reset values (async, immediate): state IDLE, all sel bits 0, drive bit 0, hist 0, skip counter 0, bit counter 0, io_InjectCount 0, io_Injecting 0. MOSI_OUT=MOSI_IN and MISO_OUT=MISO_IN during and after reset. Reset mid-injection releases the wires immediately.
- Output mux is combinational.
  - Replace mode: OUT = sel ? bit : IN.
  - XOR mode: OUT = sel ? (IN ^ bit) : IN.
  - Only the wire selected by mode bit 1 may have sel=1.
  - io_Injecting = sel_mosi | sel_miso.
- States: IDLE=0, ARMED=1, DELAY=2, INJECT=3, DONE=4.
- IDLE: sel=0. cfg_enable=1 -> ARMED on the next falling edge.
- ARMED: on a rising edge of io_MOSIReadSuccess, match io_MOSICommand against valid slots.
  - If several slots match, the lowest index wins; all matches behave identically.
  - On a match, latch cfg_pattern, cfg_mode and cfg_skip.
  - If cfg_skip=0: go to INJECT on the same edge, set sel, drive pattern[PAT_W-1], bit counter = PAT_W-1.
  - Otherwise: go to DELAY with skip counter = cfg_skip.
  - No match: stay in ARMED.
- DELAY: each io_BufferChanged rising edge decrements the skip counter.
  - The edge that brings it to 0 enters INJECT with the same actions as above, on that edge.
  - A falling edge of io_MOSIReadSuccess in DELAY (transaction ended before the target byte) returns to ARMED with no injection.
  - If both events occur on the same edge, the abort wins.
- INJECT: each falling edge with bit counter > 0 drives the next lower pattern bit and decrements the counter.
  - On the falling edge after bit 0 has been driven for one cycle: sel=0, go to DONE.
  - Each pattern bit is therefore on the wire for exactly one CLK period. Total override is PAT_W cycles.
  - INJECT is not abortable by io_MOSIReadSuccess or io_BufferChanged.
- DONE: io_InjectCount += 1, holding at 255. Then:
  - cfg_repeat=1 -> ARMED.
  - Otherwise stay in DONE until cfg_enable=0.
- cfg_enable=0 in any state: next falling edge goes to IDLE and clears sel. This truncates an in-progress injection. io_InjectCount is not incremented for a truncated injection.
- Config changes after the trigger do not affect the current injection, because values are latched. cfg_trig_* are read live in ARMED.

Test Plan:
- Basic replace: PAT_W=8, pattern 0xFD, mode 00, trig slot0=24, skip 0; pulse ReadSuccess with cmd 24 -> MOSI_OUT shows 1,1,1,1,1,1,0,1 on 8 consecutive cycles starting at the trigger edge, then follows MOSI_IN; io_InjectCount=1.
- Delay and abort: skip 3, cmd 25 matched; 2 BufferChanged edges then ReadSuccess falls -> no override, state back to ARMED; repeat with 3 edges -> injection begins on the 3rd edge.
- XOR MISO: mode 11, pattern 0x80, MISO_IN held 1 -> MISO_OUT is 0 for exactly one cycle; MOSI untouched.
- Priority and non-match: slots 55/55 both valid, cmd 17 -> no action; cmd 55 -> single injection; one-shot (repeat=0) with a second cmd 55 -> no injection, state stays DONE.
- Repeat and saturation: repeat=1, 260 triggered transactions -> io_InjectCount saturates at 255.
- Reset/enable mid-inject: assert async_reset_n low at bit 3 -> outputs equal inputs immediately, state 0; separately, drop cfg_enable at bit 3 -> sel cleared next edge, count unchanged.

Source files
------------

// File: rtl/spi_fault_injector.sv
// Inline SPI fault injector: arms on selected decoded commands, waits a number of
// byte boundaries, then replaces or XORs a pattern onto MOSI or MISO, MSB first.
module spi_fault_injector #(
    parameter int NUM_TRIG = 2,
    parameter int PAT_W    = 8,
    parameter int SKIP_W   = 8
) (
    input  logic                  CLK,
    input  logic                  async_reset_n,
    input  logic                  MOSI_IN,
    output logic                  MOSI_OUT,
    input  logic                  MISO_IN,
    output logic                  MISO_OUT,
    input  logic                  io_MOSIReadSuccess,
    input  logic [5:0]            io_MOSICommand,
    input  logic                  io_BufferChanged,
    input  logic                  cfg_enable,
    input  logic [NUM_TRIG-1:0]   cfg_trig_valid,
    input  logic [NUM_TRIG*6-1:0] cfg_trig_cmd,
    input  logic [SKIP_W-1:0]     cfg_skip,
    input  logic [PAT_W-1:0]      cfg_pattern,
    input  logic [1:0]            cfg_mode,
    input  logic                  cfg_repeat,
    output logic [7:0]            io_InjectCount,
    output logic                  io_Injecting,
    output logic [7:0]            io___dbg_state
);

    localparam int BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_DELAY  = 3'd2,
        ST_INJECT = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Every matching slot triggers identically, so the lowest-index winner reduces to an OR.
    function automatic logic trig_match(input logic [NUM_TRIG-1:0]   valid,
                                        input logic [NUM_TRIG*6-1:0] cmds,
                                        input logic [5:0]            cmd);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_TRIG; i++) begin
            hit = hit | (valid[i] & (cmds[6*i +: 6] == cmd));
        end
        return hit;
    endfunction

    state_t             state_r;
    logic               sel_mosi_r;
    logic               sel_miso_r;
    logic               drive_r;
    logic               rs_hist_r;
    logic               bc_hist_r;
    logic [SKIP_W-1:0]  skip_cnt_r;
    logic [BIT_W-1:0]   bit_cnt_r;
    logic [PAT_W-1:0]   pat_r;
    logic [1:0]         mode_r;
    logic [7:0]         inject_cnt_r;

    logic               rs_rise_s;
    logic               rs_fall_s;
    logic               bc_rise_s;
    logic               hit_s;
    logic               start_s;
    logic [PAT_W-1:0]   start_pat_s;
    logic [1:0]         start_mode_s;

    assign rs_rise_s = io_MOSIReadSuccess & ~rs_hist_r;
    assign rs_fall_s = ~io_MOSIReadSuccess & rs_hist_r;
    assign bc_rise_s = io_BufferChanged & ~bc_hist_r;
    assign hit_s     = trig_match(cfg_trig_valid, cfg_trig_cmd, io_MOSICommand);

    // Injection start: immediate on a zero-skip trigger, or on the byte edge that empties the delay.
    always_comb begin
        start_s      = 1'b0;
        start_pat_s  = pat_r;
        start_mode_s = mode_r;
        case (state_r)
            ST_ARMED: begin
                start_pat_s  = cfg_pattern;
                start_mode_s = cfg_mode;
                start_s      = rs_rise_s & hit_s & (cfg_skip == {SKIP_W{1'b0}});
            end
            ST_DELAY: begin
                start_s = ~rs_fall_s & bc_rise_s & (skip_cnt_r == SKIP_W'(1));
            end
            default: begin
                start_s = 1'b0;
            end
        endcase
    end

    // Control FSM, edge history and injection counter, all on the falling SPI edge.
    always_ff @(negedge CLK or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state_r      <= ST_IDLE;
            sel_mosi_r   <= 1'b0;
            sel_miso_r   <= 1'b0;
            drive_r      <= 1'b0;
            rs_hist_r    <= 1'b0;
            bc_hist_r    <= 1'b0;
            skip_cnt_r   <= {SKIP_W{1'b0}};
            bit_cnt_r    <= {BIT_W{1'b0}};
            pat_r        <= {PAT_W{1'b0}};
            mode_r       <= 2'b00;
            inject_cnt_r <= 8'd0;
        end else begin
            rs_hist_r <= io_MOSIReadSuccess;
            bc_hist_r <= io_BufferChanged;
            if (!cfg_enable) begin
                state_r    <= ST_IDLE;
                sel_mosi_r <= 1'b0;
                sel_miso_r <= 1'b0;
            end else if (start_s) begin
                state_r    <= ST_INJECT;
                sel_mosi_r <= ~start_mode_s[1];
                sel_miso_r <= start_mode_s[1];
                drive_r    <= start_pat_s[PAT_W-1];
                bit_cnt_r  <= BIT_W'(PAT_W - 1);
                pat_r      <= start_pat_s;
                mode_r     <= start_mode_s;
                skip_cnt_r <= {SKIP_W{1'b0}};
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_ARMED;
                    end
                    ST_ARMED: begin
                        if (rs_rise_s && hit_s) begin
                            pat_r      <= cfg_pattern;
                            mode_r     <= cfg_mode;
                            skip_cnt_r <= cfg_skip;
                            state_r    <= ST_DELAY;
                        end
                    end
                    ST_DELAY: begin
                        // A transaction ending before the target byte cancels the injection.
                        if (rs_fall_s) begin
                            state_r <= ST_ARMED;
                        end else if (bc_rise_s) begin
                            skip_cnt_r <= skip_cnt_r - SKIP_W'(1);
                        end
                    end
                    ST_INJECT: begin
                        if (bit_cnt_r != {BIT_W{1'b0}}) begin
                            drive_r   <= pat_r[bit_cnt_r - BIT_W'(1)];
                            bit_cnt_r <= bit_cnt_r - BIT_W'(1);
                        end else begin
                            sel_mosi_r <= 1'b0;
                            sel_miso_r <= 1'b0;
                            drive_r    <= 1'b0;
                            state_r    <= ST_DONE;
                            if (inject_cnt_r != 8'hFF) begin
                                inject_cnt_r <= inject_cnt_r + 8'd1;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (cfg_repeat) begin
                            state_r <= ST_ARMED;
                        end
                    end
                    default: begin
                        state_r    <= ST_IDLE;
                        sel_mosi_r <= 1'b0;
                        sel_miso_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign MOSI_OUT       = sel_mosi_r ? (mode_r[0] ? (MOSI_IN ^ drive_r) : drive_r) : MOSI_IN;
    assign MISO_OUT       = sel_miso_r ? (mode_r[0] ? (MISO_IN ^ drive_r) : drive_r) : MISO_IN;
    assign io_Injecting   = sel_mosi_r | sel_miso_r;
    assign io_InjectCount = inject_cnt_r;
    assign io___dbg_state = {5'b00000, state_r};

endmodule
